// File: rtl/pulp_clock_gating_auto.sv
// Multi-channel latch-based clock gate with per-channel idle auto-gating and
// a wake handshake that reports when a channel's clock is guaranteed running.
module pulp_clock_gating_auto #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_en_i,
    input  logic [IDLE_W-1:0] idle_thr_i,
    input  logic [NUM_CH-1:0] force_en_i,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [NUM_CH-1:0] wake_req_i,
    output logic [NUM_CH-1:0] wake_ack_o,
    output logic [NUM_CH-1:0] gated_o,
    output logic [NUM_CH-1:0] clk_o
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int CNT_W  = (IDLE_W > WAKE_W) ? IDLE_W : WAKE_W;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAKE_LAST = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_e;

    logic [CNT_W-1:0] thr_ext_s;
    logic [CNT_W-1:0] thr_last_s;

    assign thr_ext_s  = CNT_W'(idle_thr_i);
    assign thr_last_s = thr_ext_s - CNT_ONE;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             idle_s;
        logic             en_req_s;
        logic             en_latch_q;

        assign idle_s = !busy_i[c] && !wake_req_i[c];

        // Next-state and counter update for one channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_RUN: begin
                    if (!idle_s || (idle_thr_i == {IDLE_W{1'b0}})) begin
                        cnt_d = {CNT_W{1'b0}};
                    end else if (cnt_q >= thr_last_s) begin
                        // >= rather than == so a lowered threshold gates at once
                        state_d = ST_GATED;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_GATED: begin
                    if (!idle_s) begin
                        state_d = (WAKE_CYCLES == 0) ? ST_RUN : ST_WAKE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_GATED;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end

        // Channel state register with synchronous reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_RUN;
                cnt_q   <= {CNT_W{1'b0}};
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Reset keeps clocks alive so downstream synchronous resets see edges.
        assign en_req_s = rst_i | test_en_i | force_en_i[c] | (state_q != ST_GATED);

        // Enable latch, transparent in the low phase of the source clock.
        always_latch begin
            if (!clk_i) begin
                en_latch_q <= en_req_s;
            end
        end

        assign clk_o[c]      = clk_i & en_latch_q;
        assign wake_ack_o[c] = (state_q == ST_RUN);
        assign gated_o[c]    = (state_q == ST_GATED);
    end

endmodule

// File: tb/tb_pulp_clock_gating_auto.sv
// Directed, table-driven bench for pulp_clock_gating_auto with default parameters.
module tb_pulp_clock_gating_auto;

    logic       clk;
    logic       rst;
    logic       test_en;
    logic [7:0] idle_thr;
    logic [3:0] force_en;
    logic [3:0] busy;
    logic [3:0] wake_req;
    logic [3:0] wake_ack;
    logic [3:0] gated;
    logic [3:0] clk_g;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       test;
        logic [3:0] frc;
        logic [3:0] busy;
        logic [3:0] wake;
        logic [7:0] thr;
        logic [3:0] ack;
        logic [3:0] gated;
        logic [3:0] clk;
    } vec_t;

    vec_t vecs[$];

    pulp_clock_gating_auto #(
        .NUM_CH(4), .IDLE_W(8), .WAKE_CYCLES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .idle_thr_i(idle_thr),
        .force_en_i(force_en), .busy_i(busy), .wake_req_i(wake_req),
        .wake_ack_o(wake_ack), .gated_o(gated), .clk_o(clk_g)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Inputs change just after an edge; outputs are sampled 1 time unit after the next edge.
    task automatic step(input logic r, input logic t, input logic [3:0] f, input logic [3:0] b,
                        input logic [3:0] w, input logic [7:0] th);
        rst = r; test_en = t; force_en = f; busy = b; wake_req = w; idle_thr = th;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic t, input logic [3:0] f, input logic [3:0] b,
                       input logic [3:0] w, input logic [7:0] th, input logic [3:0] a,
                       input logic [3:0] g, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.test = t; v.frc = f; v.busy = b; v.wake = w; v.thr = th;
        v.ack = a; v.gated = g; v.clk = c;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; test_en = 1'b0; force_en = 4'h0; busy = 4'h0; wake_req = 4'h0; idle_thr = 8'd4;

        // reset with everything idle: clocks run, all channels report RUN
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        // auto-gate channel 0 after 4 idle edges
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hF);
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hE);
        // wake handshake, then regate after the request drops
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h1, 8'd4, 4'hE, 4'h0, 4'hE);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h1, 8'd4, 4'hE, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h1, 8'd4, 4'hF, 4'h0, 4'hF);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hF);
        // busy wakes, then a busy pulse restarts the idle count
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hE, 4'h0, 4'hE);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hE, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hE);
        // test_en and force_en override the clock without touching state
        add(1'b0, 1'b1, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hE);
        add(1'b0, 1'b0, 4'h1, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hE, 4'h1, 4'hE);
        // threshold 0 never gates
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd0, 4'hE, 4'h0, 4'hE);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd0, 4'hE, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd0, 4'hF, 4'h0, 4'hF);
        for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd0, 4'hF, 4'h0, 4'hF);
        // threshold 1 gates on the first idle edge; reset one cycle into WAKE
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd1, 4'hE, 4'h1, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h1, 8'd1, 4'hE, 4'h0, 4'hE);
        add(1'b1, 1'b0, 4'h0, 4'hE, 4'h1, 8'd1, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        // busy rising on the would-be gating edge wins
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);
        add(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd4, 4'hF, 4'h0, 4'hF);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].test, vecs[i].frc, vecs[i].busy, vecs[i].wake, vecs[i].thr);
            chk($sformatf("vec%0d_ack", i), {4'h0, wake_ack}, {4'h0, vecs[i].ack});
            chk($sformatf("vec%0d_gated", i), {4'h0, gated}, {4'h0, vecs[i].gated});
            chk($sformatf("vec%0d_clk", i), {4'h0, clk_g}, {4'h0, vecs[i].clk});
        end

        // threshold 255: gates on exactly the 255th idle edge
        step(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd255);
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd255);
            if (i >= 250) chk($sformatf("thr255_gated_%0d", i), {7'd0, gated[0]}, (i == 255) ? 8'd1 : 8'd0);
            else if (gated[0] !== 1'b0) chk($sformatf("thr255_early_%0d", i), {7'd0, gated[0]}, 8'd0);
        end
        step(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd255);
        chk("thr255_clk_off", {7'd0, clk_g[0]}, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 8'd255);
        chk("thr255_rewake_ack", {4'h0, wake_ack}, 8'h0F);

        // lowering the threshold from 10 to 2 at cnt=6 gates on the next idle edge
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd10);
        chk("lower_thr_before", {4'h0, gated}, 8'h00);
        step(1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 8'd2);
        chk("lower_thr_after", {4'h0, gated}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
